// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth signed multiplier with control FSM and datapath
module booth_multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH:0]   a_q, a_d, m_q, m_d, sum;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    counter_value;
  logic [WIDTH:0]   reg_A;
  logic [WIDTH-1:0] reg_Q;
  logic             q_minus_1;
  logic [1:0]       booth_bits;
  assign counter_value = cnt_q;
  assign reg_A         = a_q;
  assign reg_Q         = q_q;
  assign q_minus_1     = qm1_q;
  assign booth_bits    = {q_q[0], qm1_q};
  assign product       = {a_q[WIDTH-1:0], q_q};
  assign last          = cnt_q == CW'(1);
  // Load operands, or add/subtract M then arithmetic-shift {A, Q, Q-1} right by one
  always_comb begin
    sum   = booth_bits == 2'b01 ? a_q + m_q : booth_bits == 2'b10 ? a_q - m_q : a_q;
    a_d   = load ? '0 : run ? {sum[WIDTH], sum[WIDTH:1]} : a_q;
    q_d   = load ? multiplier : run ? {sum[0], q_q[WIDTH-1:1]} : q_q;
    qm1_d = load ? 1'b0 : run ? q_q[0] : qm1_q;
    m_d   = load ? {multiplicand[WIDTH-1], multiplicand} : m_q;
    cnt_d = load ? CW'(WIDTH) : run ? cnt_q - 1'b1 : cnt_q;
  end
  // Datapath registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic   done_q, done_d, load, run, last;
  booth_multiplier_datapath #(.WIDTH(WIDTH)) datapath_unit (
    .clk(clk), .rst(rst), .load(load), .run(run),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .last(last)
  );
  assign done = done_q;
  // Next state and datapath controls; done latches one edge after entering DONE
  always_comb begin
    load    = state_q == LOAD;
    run     = state_q == RUN;
    state_d = load ? RUN : (run && last) ? DONE : state_q;
    done_d  = done_q | (state_q == DONE);
  end
  // State and done registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LOAD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vector check of the Booth multiplier
module tb_booth_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  multiplicand = '0, multiplier = '0;
  logic [15:0] product;
  logic        done;
  int          checks = 0, failures = 0;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;
  vec_t vecs [8];

  booth_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'd5,   8'd3,   16'h000F};
    vecs[1] = '{8'hF9,  8'd4,   16'hFFE4};
    vecs[2] = '{8'd6,   8'hFB,  16'hFFE2};
    vecs[3] = '{8'hF8,  8'hFD,  16'h0018};
    vecs[4] = '{8'd15,  8'd0,   16'h0000};
    vecs[5] = '{8'd127, 8'd1,   16'h007F};
    vecs[6] = '{8'h80,  8'h80,  16'h4000};
    vecs[7] = '{8'h80,  8'h7F,  16'hC080};
    for (int v = 0; v < 8; v++) begin
      rst = 1'b0;
      multiplicand = vecs[v].m;
      multiplier = vecs[v].q;
      edge1();
      edge1();
      check($sformatf("v%0d reset product", v), 32'(product), 32'h0);
      check($sformatf("v%0d reset done", v), 32'(done), 32'h0);
      rst = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        edge1();
        if (e == 9) check($sformatf("v%0d done early", v), 32'(done), 32'h0);
        if (e == 10) begin
          check($sformatf("v%0d done", v), 32'(done), 32'h1);
          check($sformatf("v%0d product", v), 32'(product), 32'(vecs[v].p));
        end
      end
      multiplicand = 8'h3C;
      multiplier = 8'hA5;
      repeat (3) edge1();
      check($sformatf("v%0d done sticky", v), 32'(done), 32'h1);
      check($sformatf("v%0d product hold", v), 32'(product), 32'(vecs[v].p));
    end
    rst = 1'b0;
    multiplicand = 8'd100;
    multiplier = 8'hFD;
    edge1();
    rst = 1'b1;
    repeat (5) edge1();
    check("mid counter before abort", 32'(dut.datapath_unit.counter_value), 32'd4);
    check("mid done before abort", 32'(done), 32'h0);
    rst = 1'b0;
    edge1();
    check("abort product", 32'(product), 32'h0);
    check("abort done", 32'(done), 32'h0);
    check("abort counter", 32'(dut.datapath_unit.counter_value), 32'h0);
    check("abort reg_A", 32'(dut.datapath_unit.reg_A), 32'h0);
    check("abort reg_Q", 32'(dut.datapath_unit.reg_Q), 32'h0);
    check("abort q_minus_1", 32'(dut.datapath_unit.q_minus_1), 32'h0);
    multiplicand = 8'h80;
    multiplier = 8'h7F;
    rst = 1'b1;
    edge1();
    check("reload counter", 32'(dut.datapath_unit.counter_value), 32'd8);
    repeat (8) edge1();
    check("rerun done early", 32'(done), 32'h0);
    edge1();
    check("rerun done", 32'(done), 32'h1);
    check("rerun product", 32'(product), 32'hC080);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
